mole_game_ctrl: RTL and testbench

Game-phase controller for the whack-a-mole datapath.
- Sequences idle, normal play, fever and game-over phases on a periodic tick.
- Latches one-hot keypad presses and scores hits against the current mole pattern.
- Tracks combo and fever state, and drives the mole LEDs, score, combo digit and timer for the existing display, CLCD and sound blocks.
- Random mole patterns come from an external source.

---
 rtl/mole_game_ctrl.sv | 137 +++++++++++++
 tb/tb_mole_game_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/mole_game_ctrl.sv
// mole_game_ctrl: whack-a-mole phase controller sequencing idle, play, fever and game-over on a tick,
// scoring latched one-hot key presses against the displayed mole pattern.
module mole_game_ctrl #(
    parameter int GAME_TIME   = 45,
    parameter int FEVER_COMBO = 10,
    parameter int FEVER_TICKS = 3,
    parameter int NORMAL_PTS  = 1,
    parameter int FEVER_PTS   = 3,
    parameter int SCORE_W     = 8
) (
    input  logic               clk,
    input  logic               RESET_N,
    input  logic               start,
    input  logic               tick,
    input  logic [7:0]         keypad,
    input  logic [7:0]         rnd,
    output logic [7:0]         mole,
    output logic [SCORE_W-1:0] score,
    output logic [3:0]         combo,
    output logic [7:0]         timer,
    output logic               fever,
    output logic               game_over,
    output logic               hit_pulse
);
    typedef enum logic [1:0] {IDLE, PLAY, FEVER, OVER} state_t;

    localparam logic [7:0]       GAME_T  = 8'(GAME_TIME);
    localparam logic [3:0]       FEVER_C = 4'(FEVER_COMBO);
    localparam logic [3:0]       FEVER_N = 4'(FEVER_TICKS);
    localparam logic [SCORE_W:0] NORM_INC  = (SCORE_W+1)'(NORMAL_PTS);
    localparam logic [SCORE_W:0] FEVER_INC = (SCORE_W+1)'(FEVER_PTS);

    state_t             state, state_n;
    logic [7:0]         mole_n, timer_n, key_lat, key_lat_n, pat, timer_dec;
    logic [SCORE_W-1:0] score_n, score_sat;
    logic [SCORE_W:0]   sum;
    logic [3:0]         combo_n, fever_cnt, fever_cnt_n, combo_inc, fc1;
    logic               fever_n, game_over_n, hit, key_onehot;

    always_comb begin
        key_onehot = (keypad != 8'd0) && ((keypad & (keypad - 8'd1)) == 8'd0);
        hit        = tick && (state == PLAY || state == FEVER) && |(mole & key_lat);
        pat        = (rnd == 8'd0) ? 8'h01 : rnd;
        sum        = {1'b0, score} + ((state == FEVER) ? FEVER_INC : NORM_INC);
        score_sat  = sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
        combo_inc  = hit ? ((combo == 4'hF) ? 4'hF : combo + 4'd1) : 4'd0;
        fc1        = fever_cnt + 4'd1;
        timer_dec  = (timer == 8'd0) ? 8'd0 : timer - 8'd1;
        state_n     = state;
        mole_n      = mole;
        score_n     = score;
        combo_n     = combo;
        timer_n     = timer;
        fever_n     = fever;
        game_over_n = game_over;
        fever_cnt_n = fever_cnt;
        key_lat_n   = tick ? 8'd0 : (key_onehot ? keypad : key_lat);
        case (state)
            IDLE, OVER: begin
                if (start) begin
                    state_n     = PLAY;
                    score_n     = '0;
                    combo_n     = 4'd0;
                    fever_cnt_n = 4'd0;
                    timer_n     = GAME_T;
                    mole_n      = pat;
                    key_lat_n   = 8'd0;
                    fever_n     = 1'b0;
                    game_over_n = 1'b0;
                end else if (tick && state == OVER) begin
                    mole_n = ~mole;
                end
            end
            PLAY, FEVER: begin
                if (tick) begin
                    if (hit)
                        score_n = score_sat;
                    timer_n = timer_dec;
                    combo_n = (state == PLAY) ? combo_inc : fc1;
                    // timeout wins over both fever entry and fever exit
                    if (timer == 8'd1) begin
                        state_n     = OVER;
                        timer_n     = 8'd0;
                        fever_n     = 1'b0;
                        game_over_n = 1'b1;
                        mole_n      = 8'h00;
                        fever_cnt_n = 4'd0;
                    end else if (state == PLAY && combo_inc == FEVER_C) begin
                        state_n     = FEVER;
                        fever_n     = 1'b1;
                        fever_cnt_n = 4'd0;
                        combo_n     = 4'd0;
                        mole_n      = 8'hF0;
                    end else if (state == PLAY) begin
                        mole_n = pat;
                    end else if (fc1 == FEVER_N) begin
                        state_n     = PLAY;
                        fever_n     = 1'b0;
                        combo_n     = 4'd0;
                        fever_cnt_n = 4'd0;
                        mole_n      = pat;
                    end else begin
                        fever_cnt_n = fc1;
                        mole_n      = (mole == 8'hF0) ? 8'h0F : 8'hF0;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            state     <= IDLE;
            mole      <= 8'h00;
            score     <= '0;
            combo     <= 4'd0;
            timer     <= GAME_T;
            fever     <= 1'b0;
            game_over <= 1'b0;
            hit_pulse <= 1'b0;
            key_lat   <= 8'd0;
            fever_cnt <= 4'd0;
        end else begin
            state     <= state_n;
            mole      <= mole_n;
            score     <= score_n;
            combo     <= combo_n;
            timer     <= timer_n;
            fever     <= fever_n;
            game_over <= game_over_n;
            hit_pulse <= hit;
            key_lat   <= key_lat_n;
            fever_cnt <= fever_cnt_n;
        end
    end
endmodule

// File: tb/tb_mole_game_ctrl.sv
// tb_mole_game_ctrl: directed checks of mole_game_ctrl; a second instance with a long game
// is used to drive the score into saturation.
module tb_mole_game_ctrl;
    logic       clk = 1'b0;
    logic       RESET_N = 1'b0;
    logic       start = 1'b0, tick = 1'b0;
    logic [7:0] keypad = 8'd0, rnd = 8'd0;
    logic [7:0] mole, timer, s_mole, s_timer;
    logic [7:0] score, s_score;
    logic [3:0] combo, s_combo;
    logic       fever, game_over, hit_pulse, s_fever, s_game_over, s_hit_pulse;
    int         compared = 0;
    int         mismatched = 0;

    always #5 clk = ~clk;

    mole_game_ctrl u_dut (
        .clk(clk), .RESET_N(RESET_N), .start(start), .tick(tick), .keypad(keypad), .rnd(rnd),
        .mole(mole), .score(score), .combo(combo), .timer(timer), .fever(fever),
        .game_over(game_over), .hit_pulse(hit_pulse)
    );

    mole_game_ctrl #(.GAME_TIME(255)) u_sat (
        .clk(clk), .RESET_N(RESET_N), .start(start), .tick(tick), .keypad(keypad), .rnd(rnd),
        .mole(s_mole), .score(s_score), .combo(s_combo), .timer(s_timer), .fever(s_fever),
        .game_over(s_game_over), .hit_pulse(s_hit_pulse)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // one clock with the given inputs; returns 1 time unit after the edge
    task automatic step(input logic s, input logic t, input logic [7:0] k, input logic [7:0] r);
        start = s; tick = t; keypad = k; rnd = r;
        @(posedge clk);
        #1;
        start = 1'b0; tick = 1'b0; keypad = 8'd0;
    endtask

    task automatic press_tick(input logic [7:0] k, input logic [7:0] r);
        step(1'b0, 1'b0, k, r);
        step(1'b0, 1'b1, 8'd0, r);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 RESET_N = 1'b1;
        chk("rst_mole", mole, 8'h00);
        chk("rst_timer", timer, 45);
        chk("rst_score", score, 0);
        chk("rst_combo", combo, 0);
        chk("rst_flags", {fever, game_over, hit_pulse}, 0);
        repeat (5) step(1'b0, 1'b1, 8'd0, 8'hAA);
        chk("idle_mole", mole, 8'h00);
        chk("idle_timer", timer, 45);

        step(1'b1, 1'b0, 8'd0, 8'h00);
        chk("start_pat0", mole, 8'h01);
        chk("start_timer", timer, 45);
        press_tick(8'h01, 8'hFF);
        chk("hit1_score", score, 1);
        chk("hit1_combo", combo, 1);
        chk("hit1_timer", timer, 44);
        chk("hit1_pulse", hit_pulse, 1);
        chk("hit1_mole", mole, 8'hFF);
        step(1'b0, 1'b0, 8'd0, 8'hFF);
        chk("pulse_drop", hit_pulse, 0);
        step(1'b0, 1'b1, 8'd0, 8'hFF);
        chk("miss_combo", combo, 0);
        chk("miss_score", score, 1);
        chk("miss_timer", timer, 43);

        press_tick(8'h03, 8'hFF);
        chk("multikey_score", score, 1);
        step(1'b0, 1'b1, 8'h01, 8'hFF);
        step(1'b0, 1'b1, 8'd0, 8'hFF);
        chk("tickpress_score", score, 1);
        chk("tickpress_timer", timer, 40);

        for (int i = 0; i < 9; i++) press_tick(8'h01, 8'hFF);
        chk("combo9", combo, 9);
        chk("combo9_score", score, 10);
        press_tick(8'h01, 8'hFF);
        chk("fever_on", fever, 1);
        chk("fever_mole", mole, 8'hF0);
        chk("fever_combo0", combo, 0);
        chk("fever_score", score, 11);
        chk("fever_timer", timer, 30);
        press_tick(8'h10, 8'h55);
        chk("fv1_score", score, 14);
        chk("fv1_mole", mole, 8'h0F);
        chk("fv1_combo", combo, 1);
        press_tick(8'h01, 8'h55);
        chk("fv2_score", score, 17);
        chk("fv2_mole", mole, 8'hF0);
        chk("fv2_combo", combo, 2);
        press_tick(8'h80, 8'h55);
        chk("fv3_score", score, 20);
        chk("fv_exit_mole", mole, 8'h55);
        chk("fv_exit_flag", fever, 0);
        chk("fv_exit_combo", combo, 0);
        chk("fv_exit_timer", timer, 27);

        repeat (26) step(1'b0, 1'b1, 8'd0, 8'hFF);
        chk("pre_to_timer", timer, 1);
        chk("pre_to_go", game_over, 0);
        press_tick(8'h01, 8'hFF);
        chk("to_score", score, 21);
        chk("to_go", game_over, 1);
        chk("to_timer", timer, 0);
        chk("to_mole", mole, 8'h00);
        step(1'b0, 1'b1, 8'd0, 8'hFF);
        chk("over_mole_ff", mole, 8'hFF);
        press_tick(8'h01, 8'hFF);
        chk("over_mole_00", mole, 8'h00);
        chk("over_score", score, 21);
        chk("over_timer", timer, 0);
        step(1'b1, 1'b1, 8'd0, 8'h3C);
        chk("restart_mole", mole, 8'h3C);
        chk("restart_score", score, 0);
        chk("restart_timer", timer, 45);
        chk("restart_go", game_over, 0);
        chk("restart_combo", combo, 0);

        repeat (35) step(1'b0, 1'b1, 8'd0, 8'hFF);
        chk("prec_timer", timer, 10);
        for (int i = 0; i < 10; i++) press_tick(8'h01, 8'hFF);
        chk("prec_go", game_over, 1);
        chk("prec_fever", fever, 0);
        chk("prec_timer0", timer, 0);
        chk("prec_score", score, 10);
        chk("prec_mole", mole, 8'h00);

        step(1'b1, 1'b0, 8'd0, 8'hFF);
        press_tick(8'h01, 8'hFF);
        chk("mid_score", score, 1);
        #3 RESET_N = 1'b0;
        #1;
        chk("async_mole", mole, 8'h00);
        chk("async_timer", timer, 45);
        chk("async_score", score, 0);
        chk("async_combo", combo, 0);
        @(posedge clk);
        #1 RESET_N = 1'b1;

        step(1'b1, 1'b0, 8'd0, 8'hFF);
        for (int c = 0; c < 13; c++) begin
            for (int h = 0; h < 10; h++) press_tick(8'h01, 8'hFF);
            for (int f = 0; f < 3; f++)
                if (c < 12 || f < 2) press_tick((f == 1) ? 8'h01 : 8'h10, 8'hFF);
                else step(1'b0, 1'b1, 8'd0, 8'hFF);
        end
        chk("sat_pre_score", s_score, 244);
        for (int h = 0; h < 10; h++) press_tick(8'h01, 8'hFF);
        chk("sat_254", s_score, 254);
        chk("sat_fever", s_fever, 1);
        press_tick(8'h10, 8'hFF);
        chk("sat_255", s_score, 255);
        press_tick(8'h01, 8'hFF);
        chk("sat_hold", s_score, 255);
        chk("sat_timer", s_timer, 74);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
